// File: rtl/link_receiver_if.sv
// Inbound link, return signalling and consumer-side FIFO port of the link receiver.
// The master side is the transmitter/consumer and the slave side is the receiver.
interface link_receiver_if;
  logic [2:0] inSignal;
  logic [2:0] outSignal;
  logic       pop;
  logic [1:0] popData;
  logic       popValid;
  logic [3:0] state;

  modport master (
    output inSignal,
    output pop,
    input  outSignal,
    input  popData,
    input  popValid,
    input  state
  );

  modport slave (
    input  inSignal,
    input  pop,
    output outSignal,
    output popData,
    output popValid,
    output state
  );
endinterface

// File: rtl/link_receiver.sv
// Receiving end of the 3-bit inter-buffer link: a 4-phase req/ack capture feeding
// a small first-word-fall-through FIFO, with sticky overflow after a sustained stall.
module link_receiver #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STALL_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  link_receiver_if.slave  link
);

  localparam int         PTR_W   = $clog2(DEPTH);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [3:0] LIMIT_C = 4'(STALL_LIMIT);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LIMIT_C) ? LIMIT_C : v + 4'd1;
  endfunction

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic [0:0]             fsm;
  logic [1:0]             mem [DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [2:0]             count;
  logic [2:0]             count_nxt;
  logic                   full_r;
  logic                   valid_r;
  logic [3:0]             stall_cnt;
  logic [3:0]             stall_nxt;
  logic                   overflow;
  logic                   wr_en;
  logic                   rd_en;
  logic                   stall_hit;

  // Only the request bit is synchronised; payload is held stable by the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_sync <= '0;
    end else begin
      req_sync[0] <= link.inSignal[0];
      for (int i = 1; i < SYNC_STAGES; i++) begin
        req_sync[i] <= req_sync[i-1];
      end
    end
  end

  assign req_s = req_sync[SYNC_STAGES-1];

  // Decisions use the registered full flag, so a slot freed this cycle is usable next cycle.
  always_comb begin
    wr_en     = (fsm == IDLE) && req_s && !full_r;
    rd_en     = link.pop && valid_r;
    stall_hit = (fsm == IDLE) && req_s && full_r;
    stall_nxt = stall_hit ? sat_inc(stall_cnt) : 4'd0;
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + 3'd1;
      2'b01:   count_nxt = count - 3'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= 3'd0;
      full_r    <= 1'b0;
      valid_r   <= 1'b0;
      stall_cnt <= 4'd0;
      overflow  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 2'b00;
      end
    end else begin
      case (fsm)
        IDLE:    if (wr_en) fsm <= ACK;
        ACK:     if (!req_s) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
      if (wr_en) begin
        mem[tail] <= link.inSignal[2:1];
        tail      <= tail + PTR_W'(1);
      end
      if (rd_en) begin
        head <= head + PTR_W'(1);
      end
      count     <= count_nxt;
      full_r    <= (count_nxt == DEPTH_C);
      valid_r   <= (count_nxt != 3'd0);
      stall_cnt <= stall_nxt;
      overflow  <= overflow | (stall_nxt == LIMIT_C);
    end
  end

  assign link.outSignal = {overflow, full_r, (fsm == ACK)};
  assign link.popData   = valid_r ? mem[head] : 2'b00;
  assign link.popValid  = valid_r;
  assign link.state     = {overflow, count};

endmodule

// File: tb/tb_link_receiver.sv
// Directed bench for link_receiver with DEPTH=4, SYNC_STAGES=2, STALL_LIMIT=8.
module tb_link_receiver;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  link_receiver_if lnk();

  link_receiver #(.DEPTH(4), .SYNC_STAGES(2), .STALL_LIMIT(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (lnk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b0;
    lnk.inSignal = 3'b000;
    lnk.pop = 1'b0;
    repeat (2) tick;
    @(negedge clk);
    rst = 1'b1;
    tick;
  endtask

  task automatic pop_one;
    lnk.pop = 1'b1;
    tick;
    lnk.pop = 1'b0;
  endtask

  task automatic wait_ack_low;
    int n;
    n = 0;
    while (lnk.outSignal[0] !== 1'b0 && n < 20) begin tick; n++; end
    vectors++;
    if (lnk.outSignal[0] !== 1'b0) begin miscompares++; $display("FAIL ack_release got=%b exp=0", lnk.outSignal[0]); end
  endtask

  task automatic handshake(input logic [1:0] p);
    int n;
    lnk.inSignal = {p, 1'b1};
    n = 0;
    while (lnk.outSignal[0] !== 1'b1 && n < 20) begin tick; n++; end
    vectors++;
    if (lnk.outSignal[0] !== 1'b1) begin miscompares++; $display("FAIL handshake_ack got=%b exp=1", lnk.outSignal[0]); end
    lnk.inSignal = {p, 1'b0};
    wait_ack_low();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    lnk.inSignal = 3'b000;
    lnk.pop = 1'b0;
    #1;
    vectors++; if (lnk.outSignal !== 3'b000) begin miscompares++; $display("FAIL reset_out got=%b exp=000", lnk.outSignal); end
    vectors++; if (lnk.popValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", lnk.popValid); end
    vectors++; if (lnk.popData !== 2'b00) begin miscompares++; $display("FAIL reset_data got=%b exp=00", lnk.popData); end
    vectors++; if (lnk.state !== 4'b0000) begin miscompares++; $display("FAIL reset_state got=%b exp=0000", lnk.state); end
    repeat (2) tick;
    @(negedge clk);
    rst = 1'b1;
    tick;
  endtask

  task automatic test_latency;
    lnk.inSignal = 3'b101;
    tick; tick;
    vectors++; if (lnk.outSignal[0] !== 1'b0) begin miscompares++; $display("FAIL lat_ack_early got=%b exp=0", lnk.outSignal[0]); end
    tick;
    vectors++; if (lnk.outSignal[0] !== 1'b1) begin miscompares++; $display("FAIL lat_ack got=%b exp=1", lnk.outSignal[0]); end
    vectors++; if (lnk.state !== 4'b0001) begin miscompares++; $display("FAIL lat_state got=%b exp=0001", lnk.state); end
    vectors++; if (lnk.popValid !== 1'b1) begin miscompares++; $display("FAIL lat_valid got=%b exp=1", lnk.popValid); end
    vectors++; if (lnk.popData !== 2'b10) begin miscompares++; $display("FAIL lat_data got=%b exp=10", lnk.popData); end
    lnk.inSignal = 3'b100;
    tick; tick;
    vectors++; if (lnk.outSignal[0] !== 1'b1) begin miscompares++; $display("FAIL lat_release_early got=%b exp=1", lnk.outSignal[0]); end
    tick;
    vectors++; if (lnk.outSignal[0] !== 1'b0) begin miscompares++; $display("FAIL lat_release got=%b exp=0", lnk.outSignal[0]); end
    pop_one;
    vectors++; if (lnk.popValid !== 1'b0) begin miscompares++; $display("FAIL lat_pop_valid got=%b exp=0", lnk.popValid); end
    vectors++; if (lnk.popData !== 2'b00) begin miscompares++; $display("FAIL lat_pop_data got=%b exp=00", lnk.popData); end
    pop_one;
    vectors++; if (lnk.state !== 4'b0000) begin miscompares++; $display("FAIL underflow_state got=%b exp=0000", lnk.state); end
  endtask

  task automatic test_fill_drain;
    logic [1:0] pay [4];
    pay = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) handshake(pay[i]);
    vectors++; if (lnk.outSignal !== 3'b010) begin miscompares++; $display("FAIL fill_out got=%b exp=010", lnk.outSignal); end
    vectors++; if (lnk.state !== 4'b0100) begin miscompares++; $display("FAIL fill_state got=%b exp=0100", lnk.state); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (lnk.popData !== pay[i]) begin miscompares++; $display("FAIL drain_data[%0d] got=%b exp=%b", i, lnk.popData, pay[i]); end
      pop_one;
    end
    vectors++; if (lnk.popValid !== 1'b0) begin miscompares++; $display("FAIL drain_valid got=%b exp=0", lnk.popValid); end
    handshake(2'b11);
    vectors++; if (lnk.popData !== 2'b11) begin miscompares++; $display("FAIL refill_data got=%b exp=11", lnk.popData); end
    vectors++; if (lnk.state !== 4'b0001) begin miscompares++; $display("FAIL refill_state got=%b exp=0001", lnk.state); end
    pop_one;
  endtask

  task automatic test_overflow;
    logic [1:0] exp_q [4];
    apply_reset;
    handshake(2'b00); handshake(2'b01); handshake(2'b10); handshake(2'b11);
    lnk.inSignal = 3'b111;
    for (int k = 1; k <= 9; k++) begin
      tick;
      vectors++; if (lnk.outSignal !== 3'b010) begin miscompares++; $display("FAIL stall_out[%0d] got=%b exp=010", k, lnk.outSignal); end
    end
    tick;
    vectors++; if (lnk.state !== 4'b1100) begin miscompares++; $display("FAIL ovf_state got=%b exp=1100", lnk.state); end
    vectors++; if (lnk.outSignal !== 3'b110) begin miscompares++; $display("FAIL ovf_out got=%b exp=110", lnk.outSignal); end
    pop_one;
    vectors++; if (lnk.outSignal !== 3'b100) begin miscompares++; $display("FAIL ovf_pop_out got=%b exp=100", lnk.outSignal); end
    vectors++; if (lnk.state !== 4'b1011) begin miscompares++; $display("FAIL ovf_pop_state got=%b exp=1011", lnk.state); end
    tick;
    vectors++; if (lnk.outSignal !== 3'b111) begin miscompares++; $display("FAIL ovf_capture_out got=%b exp=111", lnk.outSignal); end
    vectors++; if (lnk.state !== 4'b1100) begin miscompares++; $display("FAIL ovf_capture_state got=%b exp=1100", lnk.state); end
    lnk.inSignal = 3'b110;
    wait_ack_low();
    exp_q = '{2'b01, 2'b10, 2'b11, 2'b11};
    for (int i = 0; i < 4; i++) begin
      vectors++; if (lnk.popData !== exp_q[i]) begin miscompares++; $display("FAIL ovf_drain[%0d] got=%b exp=%b", i, lnk.popData, exp_q[i]); end
      pop_one;
    end
    vectors++; if (lnk.state !== 4'b1000) begin miscompares++; $display("FAIL ovf_sticky got=%b exp=1000", lnk.state); end
  endtask

  task automatic test_held_req;
    apply_reset;
    lnk.inSignal = 3'b011;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (k < 3) begin
        vectors++; if (lnk.state !== 4'b0000) begin miscompares++; $display("FAIL held_state[%0d] got=%b exp=0000", k, lnk.state); end
      end else begin
        vectors++; if (lnk.state !== 4'b0001) begin miscompares++; $display("FAIL held_state[%0d] got=%b exp=0001", k, lnk.state); end
      end
    end
    lnk.inSignal = 3'b010;
    wait_ack_low();
    vectors++; if (lnk.popData !== 2'b01) begin miscompares++; $display("FAIL held_data got=%b exp=01", lnk.popData); end
  endtask

  task automatic test_back_to_back;
    apply_reset;
    handshake(2'b01);
    handshake(2'b10);
    vectors++; if (lnk.state !== 4'b0010) begin miscompares++; $display("FAIL b2b_pre_state got=%b exp=0010", lnk.state); end
    lnk.inSignal = 3'b111;
    tick; tick;
    lnk.pop = 1'b1;
    tick;
    lnk.pop = 1'b0;
    vectors++; if (lnk.outSignal[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_ack got=%b exp=1", lnk.outSignal[0]); end
    vectors++; if (lnk.state !== 4'b0010) begin miscompares++; $display("FAIL b2b_state got=%b exp=0010", lnk.state); end
    vectors++; if (lnk.popData !== 2'b10) begin miscompares++; $display("FAIL b2b_head got=%b exp=10", lnk.popData); end
    lnk.inSignal = 3'b110;
    wait_ack_low();
    pop_one;
    vectors++; if (lnk.popData !== 2'b11) begin miscompares++; $display("FAIL b2b_tail got=%b exp=11", lnk.popData); end
    pop_one;
    vectors++; if (lnk.popValid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty got=%b exp=0", lnk.popValid); end
  endtask

  task automatic test_async_reset;
    int n;
    apply_reset;
    handshake(2'b01);
    handshake(2'b10);
    lnk.inSignal = 3'b111;
    n = 0;
    while (lnk.outSignal[0] !== 1'b1 && n < 20) begin tick; n++; end
    vectors++; if (lnk.state !== 4'b0011 || lnk.outSignal[0] !== 1'b1) begin miscompares++; $display("FAIL ar_pre got=%b/%b exp=0011/1", lnk.state, lnk.outSignal[0]); end
    #2;
    rst = 1'b0;
    #1;
    vectors++; if (lnk.outSignal !== 3'b000) begin miscompares++; $display("FAIL ar_out got=%b exp=000", lnk.outSignal); end
    vectors++; if (lnk.popValid !== 1'b0) begin miscompares++; $display("FAIL ar_valid got=%b exp=0", lnk.popValid); end
    vectors++; if (lnk.popData !== 2'b00) begin miscompares++; $display("FAIL ar_data got=%b exp=00", lnk.popData); end
    vectors++; if (lnk.state !== 4'b0000) begin miscompares++; $display("FAIL ar_state got=%b exp=0000", lnk.state); end
    @(negedge clk);
    rst = 1'b1;
    tick; tick;
    vectors++; if (lnk.outSignal[0] !== 1'b0 || lnk.state !== 4'b0000) begin miscompares++; $display("FAIL ar_early got=%b/%b exp=0/0000", lnk.outSignal[0], lnk.state); end
    tick;
    vectors++; if (lnk.outSignal[0] !== 1'b1) begin miscompares++; $display("FAIL ar_recap_ack got=%b exp=1", lnk.outSignal[0]); end
    vectors++; if (lnk.state !== 4'b0001) begin miscompares++; $display("FAIL ar_recap_state got=%b exp=0001", lnk.state); end
    vectors++; if (lnk.popData !== 2'b11) begin miscompares++; $display("FAIL ar_recap_data got=%b exp=11", lnk.popData); end
    lnk.inSignal = 3'b110;
    wait_ack_low();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset;
    test_latency;
    test_fill_drain;
    test_overflow;
    test_held_req;
    test_back_to_back;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
